// File: rtl/hidden_reader.sv
// Snapshots the hidden-neuron bus on start and streams it out
// GROUP neurons per beat over a valid/ready handshake.
module hidden_reader #(
    parameter int NUM   = 20,
    parameter int W     = 8,
    parameter int GROUP = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM*W-1:0]     hidden_concat,
    output logic                 hidden_free,
    output logic [GROUP*W-1:0]   out_data,
    output logic [4:0]           out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int BEATS = NUM / GROUP;
    localparam int GW    = GROUP * W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [NUM*W-1:0]  snap;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nxt;
    logic [GW-1:0]     beat_of [BEATS];

    assign nxt = cnt + 1'b1;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_of[b] = snap[b*GW +: GW];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            snap        <= '0;
            cnt         <= '0;
            out_data    <= '0;
            out_idx     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hidden_free <= 1'b0;
        end else begin
            hidden_free <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // First beat comes straight off the bus so it is
                        // valid the cycle after capture.
                        snap        <= hidden_concat;
                        cnt         <= '0;
                        state       <= SEND;
                        hidden_free <= 1'b1;
                        busy        <= 1'b1;
                        out_valid   <= 1'b1;
                        out_data    <= hidden_concat[GW-1:0];
                        out_idx     <= '0;
                        out_last    <= (BEATS == 1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (32'(cnt) == BEATS - 1) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            cnt      <= nxt;
                            out_data <= beat_of[nxt];
                            out_idx  <= 5'(32'(nxt) * GROUP);
                            out_last <= (32'(nxt) == BEATS - 1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
